// File: rtl/vis_stream_packer.sv
// Serialises correlator visibility sets into a byte-wide framed stream for the host link.
// Frame: 'T' 'V' seq_lo seq_hi, then NB bytes re and NB bytes im per visibility, then a status byte.
module vis_stream_packer #(
   parameter int ACCUM = 36,
   parameter int CORES = 18,
   parameter int TRATE = 30
) (
   input  logic             bus_clock,
   input  logic             reset_n,
   input  logic [ACCUM-1:0] bus_revis_i,
   input  logic [ACCUM-1:0] bus_imvis_i,
   input  logic             bus_valid_i,
   output logic             bus_ready_o,
   input  logic             bus_last_i,
   output logic [7:0]       m_tdata_o,
   output logic             m_tvalid_o,
   input  logic             m_tready_i,
   output logic             m_tlast_o,
   output logic [15:0]      frame_seq_o,
   output logic [7:0]       err_count_o
);
   localparam int TOTAL = CORES * TRATE;
   localparam int NB    = (ACCUM + 7) / 8;
   localparam int SW    = 2 * NB * 8;
   localparam int IW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam int BW    = $clog2(2 * NB);
   localparam logic [IW-1:0] LAST_IDX  = IW'(TOTAL - 1);
   localparam logic [BW-1:0] LAST_BYTE = BW'(2 * NB - 1);

   typedef enum logic [2:0] {IDLE, HDR0, HDR1, SEQ0, SEQ1, LOAD, SEND, STAT} state_t;

   state_t         state_q;
   logic           bus_ready_q;
   logic           m_tvalid_q;
   logic [7:0]     m_tdata_q;
   logic           m_tlast_q;
   logic [15:0]    seq_q;
   logic [7:0]     err_q;
   logic [IW-1:0]  idx_q;
   logic [BW-1:0]  byte_q;
   logic [SW-1:0]  shift_q;
   logic           early_q;
   logic           missing_q;
   logic           end_q;

   logic [NB*8-1:0] re_ext;
   logic [NB*8-1:0] im_ext;
   logic [SW-1:0]   cap_word;
   logic            out_acc;
   logic            in_acc;
   logic            at_end_idx;
   logic            early_d;
   logic            missing_d;

   generate
      if (NB * 8 > ACCUM) begin : g_sext
         assign re_ext = {{(NB*8-ACCUM){bus_revis_i[ACCUM-1]}}, bus_revis_i};
         assign im_ext = {{(NB*8-ACCUM){bus_imvis_i[ACCUM-1]}}, bus_imvis_i};
      end else begin : g_nosext
         assign re_ext = bus_revis_i;
         assign im_ext = bus_imvis_i;
      end
   endgenerate

   // Real part sits in the low half so it leaves first, LSB first.
   assign cap_word   = {im_ext, re_ext};
   assign out_acc    = m_tvalid_q & m_tready_i;
   assign in_acc     = bus_valid_i & bus_ready_q;
   assign at_end_idx = (idx_q == LAST_IDX);
   assign early_d    = bus_last_i & ~at_end_idx;
   assign missing_d  = ~bus_last_i & at_end_idx;

   always_ff @(posedge bus_clock) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         bus_ready_q <= 1'b0;
         m_tvalid_q  <= 1'b0;
         m_tdata_q   <= 8'h00;
         m_tlast_q   <= 1'b0;
         seq_q       <= 16'h0000;
         err_q       <= 8'h00;
         idx_q       <= '0;
         byte_q      <= '0;
         shift_q     <= '0;
         early_q     <= 1'b0;
         missing_q   <= 1'b0;
         end_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (bus_valid_i) begin
               m_tvalid_q <= 1'b1;
               m_tdata_q  <= 8'h54;
               state_q    <= HDR0;
            end
            HDR0: if (out_acc) begin
               m_tdata_q <= 8'h56;
               state_q   <= HDR1;
            end
            HDR1: if (out_acc) begin
               m_tdata_q <= seq_q[7:0];
               state_q   <= SEQ0;
            end
            SEQ0: if (out_acc) begin
               m_tdata_q <= seq_q[15:8];
               state_q   <= SEQ1;
            end
            SEQ1: if (out_acc) begin
               m_tvalid_q  <= 1'b0;
               bus_ready_q <= 1'b1;
               state_q     <= LOAD;
            end
            LOAD: if (in_acc) begin
               bus_ready_q <= 1'b0;
               m_tvalid_q  <= 1'b1;
               m_tdata_q   <= cap_word[7:0];
               shift_q     <= cap_word >> 8;
               byte_q      <= '0;
               early_q     <= early_d;
               missing_q   <= missing_d;
               end_q       <= bus_last_i | at_end_idx;
               state_q     <= SEND;
            end
            SEND: if (out_acc) begin
               if (byte_q == LAST_BYTE) begin
                  if (end_q) begin
                     m_tdata_q <= {6'b0, missing_q, early_q};
                     m_tlast_q <= 1'b1;
                     state_q   <= STAT;
                  end else begin
                     idx_q       <= idx_q + IW'(1);
                     m_tvalid_q  <= 1'b0;
                     bus_ready_q <= 1'b1;
                     state_q     <= LOAD;
                  end
               end else begin
                  m_tdata_q <= shift_q[7:0];
                  shift_q   <= shift_q >> 8;
                  byte_q    <= byte_q + BW'(1);
               end
            end
            STAT: if (out_acc) begin
               m_tvalid_q <= 1'b0;
               m_tlast_q  <= 1'b0;
               seq_q      <= seq_q + 16'd1;
               if ((early_q | missing_q) && (err_q != 8'hFF))
                  err_q <= err_q + 8'd1;
               early_q    <= 1'b0;
               missing_q  <= 1'b0;
               end_q      <= 1'b0;
               idx_q      <= '0;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus_ready_o = bus_ready_q;
   assign m_tvalid_o  = m_tvalid_q;
   assign m_tdata_o   = m_tdata_q;
   assign m_tlast_o   = m_tlast_q;
   assign frame_seq_o = seq_q;
   assign err_count_o = err_q;
endmodule

// File: tb/tb_vis_stream_packer.sv
// Directed frame-level bench for vis_stream_packer with a small frame (TOTAL=6).
module tb_vis_stream_packer;
   localparam int ACCUM = 36;
   localparam int CORES = 2;
   localparam int TRATE = 3;

   logic             clk;
   logic             reset_n;
   logic [ACCUM-1:0] bus_revis_i;
   logic [ACCUM-1:0] bus_imvis_i;
   logic             bus_valid_i;
   logic             bus_ready_o;
   logic             bus_last_i;
   logic [7:0]       m_tdata_o;
   logic             m_tvalid_o;
   logic             m_tready_i;
   logic             m_tlast_o;
   logic [15:0]      frame_seq_o;
   logic [7:0]       err_count_o;

   vis_stream_packer #(.ACCUM(ACCUM), .CORES(CORES), .TRATE(TRATE)) dut (
      .bus_clock   (clk),
      .reset_n     (reset_n),
      .bus_revis_i (bus_revis_i),
      .bus_imvis_i (bus_imvis_i),
      .bus_valid_i (bus_valid_i),
      .bus_ready_o (bus_ready_o),
      .bus_last_i  (bus_last_i),
      .m_tdata_o   (m_tdata_o),
      .m_tvalid_o  (m_tvalid_o),
      .m_tready_i  (m_tready_i),
      .m_tlast_o   (m_tlast_o),
      .frame_seq_o (frame_seq_o),
      .err_count_o (err_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [35:0] re;
      logic [35:0] im;
      logic        last;
   } word_t;

   typedef struct {
      int          nwords;
      int          last_pos;
      bit          rnd;
      int          pat;
      logic [7:0]  exp_status;
      int          exp_len;
      logic [15:0] exp_seq;
      logic [7:0]  exp_err;
   } vec_t;

   word_t      in_q[$];
   logic [7:0] got_d[$];
   logic       got_l[$];
   logic [7:0] exp_q[$];

   int   passed = 0;
   int   total  = 0;
   bit   rnd_ready = 1'b0;
   int   stall_viol;
   int   ready_viol;
   bit   prev_stall;
   logic [7:0] prev_data;
   logic       prev_last;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h, required %0h", name, act, req);
   endtask

   task automatic drive();
      m_tready_i = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (in_q.size() > 0) begin
         bus_valid_i = 1'b1;
         bus_revis_i = in_q[0].re;
         bus_imvis_i = in_q[0].im;
         bus_last_i  = in_q[0].last;
      end else begin
         bus_valid_i = 1'b0;
         bus_last_i  = 1'b0;
      end
   endtask

   // One clock: drive at the falling edge, log the handshakes the next rising edge will take.
   task automatic cycle();
      @(negedge clk);
      drive();
      if (prev_stall && !(m_tvalid_o && m_tdata_o == prev_data && m_tlast_o == prev_last))
         stall_viol++;
      if (bus_ready_o && m_tvalid_o) ready_viol++;
      if (m_tvalid_o && m_tready_i) begin
         got_d.push_back(m_tdata_o);
         got_l.push_back(m_tlast_o);
      end
      if (bus_valid_i && bus_ready_o) in_q.delete(0);
      prev_stall = m_tvalid_o && !m_tready_i;
      prev_data  = m_tdata_o;
      prev_last  = m_tlast_o;
   endtask

   task automatic exp_comp(input logic [35:0] x);
      logic [39:0] e;
      e = {{4{x[35]}}, x};
      for (int b = 0; b < 5; b++) exp_q.push_back(e[b*8 +: 8]);
   endtask

   task automatic load_frame(input vec_t v);
      word_t       w;
      logic [15:0] seq_before;
      logic [31:0] r32;
      seq_before = v.exp_seq - 16'd1;
      exp_q.delete();
      exp_q.push_back(8'h54);
      exp_q.push_back(8'h56);
      exp_q.push_back(seq_before[7:0]);
      exp_q.push_back(seq_before[15:8]);
      for (int k = 0; k < v.nwords; k++) begin
         if (v.pat == 0) begin
            w.re = 36'(k);
            w.im = -36'(k);
         end else begin
            r32 = $urandom();
            w.re = (k == 0) ? 36'h7FFFFFFFF : (k == 1) ? 36'h800000000 :
                   {4'($urandom_range(0, 15)), r32};
            r32 = $urandom();
            w.im = {4'($urandom_range(0, 15)), r32};
         end
         w.last = (k == v.last_pos);
         in_q.push_back(w);
         exp_comp(w.re);
         exp_comp(w.im);
      end
      exp_q.push_back(v.exp_status);
      got_d.delete();
      got_l.delete();
      stall_viol = 0;
      ready_viol = 0;
      prev_stall = 1'b0;
      rnd_ready  = v.rnd;
   endtask

   task automatic finish_frame(input vec_t v, input string tag);
      int n;
      int bad;
      int nlast;
      n = 0;
      while (!(got_l.size() > 0 && got_l[got_l.size()-1] == 1'b1) && n < 2000) begin
         cycle();
         n++;
      end
      check({tag, "_done"}, 32'(n < 2000), 32'd1);
      @(negedge clk);
      bus_valid_i = 1'b0;
      m_tready_i  = 1'b0;
      bad = -1;
      for (int i = 0; i < got_d.size() && i < exp_q.size(); i++)
         if (bad < 0 && got_d[i] !== exp_q[i]) bad = i;
      if (bad >= 0)
         $display("FAIL %s_byte: at %0d got %02h, required %02h", tag, bad, got_d[bad], exp_q[bad]);
      nlast = 0;
      foreach (got_l[i]) if (got_l[i]) nlast++;
      check({tag, "_len"}, 32'(got_d.size()), 32'(v.exp_len));
      check({tag, "_first_bad_byte"}, 32'(bad), 32'hFFFFFFFF);
      check({tag, "_status"}, {24'd0, got_d[got_d.size()-1]}, {24'd0, v.exp_status});
      check({tag, "_tlast_count"}, 32'(nlast), 32'd1);
      check({tag, "_seq"}, {16'd0, frame_seq_o}, {16'd0, v.exp_seq});
      check({tag, "_err"}, {24'd0, err_count_o}, {24'd0, v.exp_err});
      check({tag, "_stall_hold"}, 32'(stall_viol), 32'd0);
      check({tag, "_ready_vs_valid"}, 32'(ready_viol), 32'd0);
      check({tag, "_idle_ready"}, {31'd0, bus_ready_o}, 32'd0);
      check({tag, "_words_left"}, 32'(in_q.size()), 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_bus_ready"}, {31'd0, bus_ready_o}, 32'd0);
      check({tag, "_tvalid"}, {31'd0, m_tvalid_o}, 32'd0);
      check({tag, "_tdata"}, {24'd0, m_tdata_o}, 32'd0);
      check({tag, "_tlast"}, {31'd0, m_tlast_o}, 32'd0);
      check({tag, "_seq"}, {16'd0, frame_seq_o}, 32'd0);
      check({tag, "_err"}, {24'd0, err_count_o}, 32'd0);
   endtask

   vec_t vecs[7];
   vec_t v;

   initial begin
      //        nwords last rnd pat status len seq    err
      vecs[0] = '{6, 5,  1'b0, 0, 8'h00, 65, 16'd1, 8'd0};
      vecs[1] = '{3, 2,  1'b0, 1, 8'h01, 35, 16'd2, 8'd1};
      vecs[2] = '{6, -1, 1'b0, 1, 8'h02, 65, 16'd3, 8'd2};
      vecs[3] = '{6, 5,  1'b1, 1, 8'h00, 65, 16'd4, 8'd2};
      vecs[4] = '{3, 2,  1'b1, 1, 8'h01, 35, 16'd5, 8'd3};
      vecs[5] = '{6, -1, 1'b1, 1, 8'h02, 65, 16'd6, 8'd4};
      vecs[6] = '{1, 0,  1'b0, 1, 8'h01, 15, 16'd7, 8'd5};

      reset_n     = 1'b0;
      bus_valid_i = 1'b0;
      bus_last_i  = 1'b0;
      bus_revis_i = '0;
      bus_imvis_i = '0;
      m_tready_i  = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("por");
      reset_n = 1'b1;

      for (int r = 0; r < 7; r++) begin
         load_frame(vecs[r]);
         finish_frame(vecs[r], $sformatf("row%0d", r));
         if (r == 0) begin
            check("row0_word1_re_b0", {24'd0, got_d[14]}, 32'h01);
            check("row0_word1_re_b4", {24'd0, got_d[18]}, 32'h00);
            check("row0_word1_im_b0", {24'd0, got_d[19]}, 32'hFF);
            check("row0_word1_im_b4", {24'd0, got_d[23]}, 32'hFF);
         end
      end

      // Abandon a frame partway through its payload with a one-cycle reset.
      v = '{6, 5, 1'b0, 0, 8'h00, 65, 16'd8, 8'd5};
      load_frame(v);
      for (int n = 0; n < 2000 && got_d.size() < 20; n++) cycle();
      check("midrst_reached_byte20", 32'(got_d.size()), 32'd20);
      @(negedge clk);
      reset_n     = 1'b0;
      bus_valid_i = 1'b0;
      m_tready_i  = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      check_reset_vals("midrst");
      in_q.delete();
      v = '{6, 5, 1'b0, 0, 8'h00, 65, 16'd1, 8'd0};
      load_frame(v);
      finish_frame(v, "post_rst");

      // Error counter saturation over 256 one-word early-last frames.
      for (int i = 0; i < 256; i++) begin
         v = '{1, 0, 1'b0, 1, 8'h01, 15, 16'(2 + i), (i + 1 > 255) ? 8'd255 : 8'(i + 1)};
         load_frame(v);
         finish_frame(v, $sformatf("sat%0d", i));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
